// File: rtl/jt51_wrq.sv
// rtl/jt51_wrq.sv - two-requester write queue draining address/data pairs onto the jt51 register pins
// Optional feature macro: JT51_WRQ_BUSYPOLL_EN (busy polling; otherwise a HOLD-tick countdown paces writes)
module jt51_wrq #(
  parameter int DEPTH = 8,
  parameter int HOLD  = 68
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cen_p1,
  input  logic                   req0_valid,
  input  logic [7:0]             req0_addr,
  input  logic [7:0]             req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [7:0]             req1_addr,
  input  logic [7:0]             req1_data,
  output logic                   req1_ready,
  input  logic                   busy,
  output logic                   cs_n,
  output logic                   wr_n,
  output logic                   a0,
  output logic [7:0]             wr_din,
  output logic [$clog2(DEPTH):0] level,
  output logic                   idle
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int HW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ADDR, S_GAP, S_DATA} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          last_q, last_d;
  logic          cs_n_q, cs_n_d, wr_n_q, wr_n_d, a0_q, a0_d;
  logic [7:0]    din_q, din_d;
  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   head, push_word;
  logic          full, empty, grant0, grant1, push, pop, wait_done;

  assign full  = (count_q == LW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // last_q=1 means req1 won the previous accepted push, so req0 wins the next tie
  assign grant0     = req0_valid && (!req1_valid || last_q);
  assign grant1     = req1_valid && !grant0;
  assign req0_ready = rst_n && grant0 && !full;
  assign req1_ready = rst_n && grant1 && !full;
  assign push       = req0_ready || req1_ready;
  assign push_word  = grant1 ? {req1_addr, req1_data} : {req0_addr, req0_data};
  assign pop        = cen_p1 && (state_q == S_DATA);

  always_comb begin
    wr_ptr_d = wr_ptr_q + (push ? AW'(1) : AW'(0));
    rd_ptr_d = rd_ptr_q + (pop ? AW'(1) : AW'(0));
    last_d   = push ? grant1 : last_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

`ifdef JT51_WRQ_BUSYPOLL_EN
  assign wait_done = !busy;
`else
  logic [HW-1:0] hold_q, hold_d;
  logic          unused_busy;
  assign unused_busy = busy;
  assign wait_done   = (hold_q == '0);

  always_comb begin
    hold_d = hold_q;
    if (pop)                        hold_d = HW'(HOLD);
    else if (cen_p1 && hold_q != '0) hold_d = hold_q - HW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cen_p1) begin
      case (state_q)
        S_IDLE:  if (!empty) state_d = S_WAIT;
        S_WAIT:  if (wait_done) state_d = S_ADDR;
        S_ADDR:  state_d = S_GAP;
        S_GAP:   state_d = S_DATA;
        S_DATA:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Pin values decoded from the state being entered so strobes come straight from flops
  always_comb begin
    cs_n_d = 1'b1;
    wr_n_d = 1'b1;
    a0_d   = a0_q;
    din_d  = din_q;
    case (state_d)
      S_ADDR: begin cs_n_d = 1'b0; wr_n_d = 1'b0; a0_d = 1'b0; din_d = head[15:8]; end
      S_DATA: begin cs_n_d = 1'b0; wr_n_d = 1'b0; a0_d = 1'b1; din_d = head[7:0];  end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= 1'b1;
      cs_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      a0_q     <= 1'b0;
      din_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
      if (cen_p1) begin
        cs_n_q <= cs_n_d;
        wr_n_q <= wr_n_d;
        a0_q   <= a0_d;
        din_q  <= din_d;
      end
    end
  end

  assign cs_n   = cs_n_q;
  assign wr_n   = wr_n_q;
  assign a0     = a0_q;
  assign wr_din = din_q;
  assign level  = count_q;
  assign idle   = empty && (state_q == S_IDLE);
endmodule

// File: tb/tb_jt51_wrq.sv
// tb/tb_jt51_wrq.sv - directed self-checking bench for jt51_wrq
module tb_jt51_wrq;
  localparam int DEPTH = 8;
  localparam int HOLD  = 4;
`ifdef JT51_WRQ_BUSYPOLL_EN
  localparam int PAIR_GAP = 3;
`else
  localparam int PAIR_GAP = HOLD + 2;
`endif

  logic       clk = 1'b0, rst_n = 1'b0, cen_p1 = 1'b0, cen_en = 1'b0, busy = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_addr = '0, req0_data = '0, req1_addr = '0, req1_data = '0;
  logic       req0_ready, req1_ready, cs_n, wr_n, a0, idle;
  logic [7:0] wr_din;
  logic [3:0] level;

  int compared = 0, mismatched = 0;
  int ecnt = 0;
  logic [15:0] pin_log [$];
  int          addr_e [$];
  int          data_e [$];
  int          seq_err = 0, stab_err = 0, bad_width = 0, n_strobes = 0, width = 0;
  logic        have_addr = 1'b0, in_strobe = 1'b0;
  logic [7:0]  cur_addr = '0, cap = '0;

  jt51_wrq #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .cen_p1(cen_p1),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .busy(busy), .cs_n(cs_n), .wr_n(wr_n), .a0(a0), .wr_din(wr_din), .level(level), .idle(idle)
  );

  always #5 clk = ~clk;
  always @(negedge clk) cen_p1 = cen_en && !cen_p1;
  always @(posedge clk) if (cen_p1) ecnt <= ecnt + 1;

  // Pin monitor: rebuilds {addr,data} pairs and stamps each strobe with its enabled-edge index
  always @(negedge clk) begin
    if (!rst_n) begin
      have_addr = 1'b0;
      in_strobe = 1'b0;
    end else begin
      if (cs_n !== wr_n) seq_err++;
      if (!wr_n && !in_strobe) begin
        in_strobe = 1'b1;
        width     = 1;
        cap       = wr_din;
        n_strobes++;
        if (!a0) begin
          have_addr = 1'b1;
          cur_addr  = wr_din;
          addr_e.push_back(ecnt);
        end else begin
          if (!have_addr) seq_err++;
          else pin_log.push_back({cur_addr, wr_din});
          have_addr = 1'b0;
          data_e.push_back(ecnt);
        end
      end else if (!wr_n) begin
        width++;
        if (wr_din !== cap) stab_err++;
      end else if (in_strobe) begin
        in_strobe = 1'b0;
        if (width != 2) bad_width++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    pin_log.delete();
    addr_e.delete();
    data_e.delete();
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cen_en     = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_logs();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (!(idle && wr_n) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, n < 3000, 1);
  endtask

  logic [15:0] t0 [3] = '{16'h0801, 16'h0902, 16'h0a03};
  logic [15:0] t1 [3] = '{16'h2811, 16'h2912, 16'h2a13};
  logic [15:0] exp_q [$];

  initial begin
    int push_e, rel_e, i0, i1, acc, ns, n;
    logic w;

    // Reset values, with both requesters asserting valid
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 1);
    check("rst_wr_n", wr_n, 1);
    check("rst_a0", a0, 0);
    check("rst_wr_din", wr_din, 0);
    check("rst_level", level, 0);
    check("rst_idle", idle, 1);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    do_reset();

    // Single write 0x14/0x15
    cen_en = 1'b1;
    repeat (4) @(negedge clk);
    req0_valid = 1'b1; req0_addr = 8'h14; req0_data = 8'h15;
    #1 check("single_ready", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    push_e = ecnt;
    check("single_level1", level, 1);
    check("single_idle0", idle, 0);
    wait_idle("single");
    check("single_npairs", pin_log.size(), 1);
    if (pin_log.size() == 1) begin
      check("single_pair", pin_log[0], 16'h1415);
      check("single_addr_edge", addr_e[0], push_e + 2);
      check("single_data_edge", data_e[0], addr_e[0] + 2);
    end
    check("single_level0", level, 0);
    check("single_idle1", idle, 1);

    // Round-robin arbitration with both requesters always valid
    do_reset();
    exp_q.delete();
    i0 = 0; i1 = 0; w = 1'b0;
    for (int k = 0; k < 6; k++) begin
      req0_valid = (i0 < 3); req1_valid = (i1 < 3);
      {req0_addr, req0_data} = t0[i0 % 3];
      {req1_addr, req1_data} = t1[i1 % 3];
      #1;
      check("arb_ready0", req0_ready, !w);
      check("arb_ready1", req1_ready, w);
      if (!w) begin exp_q.push_back(t0[i0]); i0++; end
      else    begin exp_q.push_back(t1[i1]); i1++; end
      w = !w;
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("arb_level", level, 6);
    cen_en = 1'b1;
    wait_idle("arb");
    check("arb_npairs", pin_log.size(), 6);
    if (pin_log.size() == 6)
      for (int k = 0; k < 6; k++) check($sformatf("arb_pin%0d", k), pin_log[k], exp_q[k]);

    // Full FIFO: 10 back-to-back attempts, drain stalled
    do_reset();
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      req0_valid = 1'b1;
      req0_addr  = 8'h20 + 8'(acc);
      req0_data  = 8'h40 + 8'(acc);
      #1 if (req0_ready) acc++;
      @(negedge clk);
    end
    req1_valid = 1'b1;
    #1;
    check("full_accepted", acc, 8);
    check("full_level", level, DEPTH);
    check("full_ready0", req0_ready, 0);
    check("full_ready1", req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("full_level_hold", level, DEPTH);
    cen_en = 1'b1;
    wait_idle("full");
    check("full_npairs", pin_log.size(), 8);
    if (pin_log.size() == 8) begin
      for (int k = 0; k < 8; k++)
        check($sformatf("full_pin%0d", k), pin_log[k], {8'h20 + 8'(k), 8'h40 + 8'(k)});
      for (int k = 0; k < 7; k++)
        check($sformatf("full_gap%0d", k), addr_e[k+1] - data_e[k], PAIR_GAP);
    end
    check("full_idle", idle, 1);
    check("full_level0", level, 0);

`ifdef JT51_WRQ_BUSYPOLL_EN
    // Busy held for 20 ticks with one entry queued
    do_reset();
    busy = 1'b1; cen_en = 1'b1;
    req0_valid = 1'b1; req0_addr = 8'h30; req0_data = 8'h31;
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (40) @(negedge clk);
    check("busy_no_strobe", n_strobes == 0 || addr_e.size() == 0, 1);
    busy = 1'b0;
    rel_e = ecnt;
    wait_idle("busy");
    check("busy_npairs", addr_e.size(), 1);
    if (addr_e.size() == 1) check("busy_addr_edge", addr_e[0], rel_e + 1);
`endif

    // Reset while in GAP with three entries queued
    do_reset();
    for (int k = 0; k < 3; k++) begin
      req0_valid = 1'b1; req0_addr = 8'h50 + 8'(k); req0_data = 8'h60 + 8'(k);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    cen_en = 1'b1;
    n = 0;
    while (!(addr_e.size() == 1 && wr_n) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rstgap_reach_timeout", n < 200, 1);
    check("rstgap_level_before", level, 3);
    rst_n = 1'b0;
    #1;
    check("rstgap_cs_n", cs_n, 1);
    check("rstgap_wr_n", wr_n, 1);
    check("rstgap_level", level, 0);
    check("rstgap_idle", idle, 1);
    @(negedge clk);
    rst_n = 1'b1;
    ns = n_strobes;
    repeat (40) @(negedge clk);
    check("rstgap_no_strobe", n_strobes, ns);
    check("rstgap_idle_after", idle, 1);

    check("mon_pair_seq", seq_err, 0);
    check("mon_din_stable", stab_err, 0);
    check("mon_strobe_width", bad_width, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
